// File: rtl/corner_switch_scheduler.sv
// Switch-allocation controller for a 3-port corner router: routes FIFO heads, arbitrates
// round-robin per output and holds a wormhole lock until the tail flit has transferred.
module corner_switch_scheduler #(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned HORIZ_PORT = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [7:0]                          local_addr,
    input  logic [NUM_PORTS-1:0]                packet_valid,
    input  logic [NUM_PORTS-1:0][7:0]           packet_addr,
    input  logic [NUM_PORTS-1:0]                packet_tail,
    input  logic [NUM_PORTS-1:0]                buffer_full_in,
    output logic [NUM_PORTS-1:0][NUM_PORTS-1:0] grant_sel,
    output logic [NUM_PORTS-1:0]                grant_v,
    output logic [NUM_PORTS-1:0]                pop_v,
    output logic                                route_err
);

    // ST_GAP is the single dead cycle an output spends after any tail transfer.
    typedef enum logic [1:0] {ST_IDLE, ST_LOCKED, ST_GAP} state_e;

    localparam logic [1:0] LOCAL_OUT = 2'd2;
    localparam logic [1:0] H_OUT     = 2'(HORIZ_PORT);
    localparam logic [1:0] V_OUT     = 2'(1 - HORIZ_PORT);

    function automatic logic [1:0] wrap_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    state_e                      state_q [NUM_PORTS];
    state_e                      state_d [NUM_PORTS];
    logic [NUM_PORTS-1:0][1:0]   owner_q, owner_d;
    logic [NUM_PORTS-1:0][1:0]   rr_q, rr_d;
    logic                        route_err_q, route_err_d;

    logic [NUM_PORTS-1:0][1:0]   route;
    logic [NUM_PORTS-1:0]        uturn;
    logic [NUM_PORTS-1:0]        req_v;
    logic [NUM_PORTS-1:0]        held;

    always_comb begin : routing
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (packet_addr[i] == local_addr) begin
                route[i] = LOCAL_OUT;
            end else if (packet_addr[i][7:4] != local_addr[7:4]) begin
                route[i] = H_OUT;
            end else begin
                route[i] = V_OUT;
            end
            uturn[i] = (i < 32'd2) && (route[i] == 2'(i));
            req_v[i] = packet_valid[i] & ~uturn[i];
        end
        held = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            if (state_q[o] == ST_LOCKED) begin
                held[owner_q[o]] = 1'b1;
            end
        end
        route_err_d = route_err_q | (|(packet_valid & uturn));
    end

    always_comb begin : arbitration
        logic [NUM_PORTS-1:0] cand;
        logic [1:0]           scan;
        logic [1:0]           win;
        logic                 found;
        cand  = '0;
        scan  = '0;
        win   = '0;
        found = 1'b0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            grant_sel[o] = '0;
            state_d[o]   = state_q[o];
            owner_d[o]   = owner_q[o];
            rr_d[o]      = rr_q[o];

            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                cand[i] = req_v[i] & (route[i] == 2'(o)) & ~held[i];
            end
            found = 1'b0;
            win   = rr_q[o];
            scan  = rr_q[o];
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                if (!found && cand[scan]) begin
                    found = 1'b1;
                    win   = scan;
                end
                scan = wrap_inc(scan);
            end

            case (state_q[o])
                ST_IDLE: begin
                    if (found && !buffer_full_in[o]) begin
                        grant_sel[o][win] = 1'b1;
                        if (packet_tail[win]) begin
                            state_d[o] = ST_GAP;
                            rr_d[o]    = wrap_inc(win);
                        end else begin
                            state_d[o] = ST_LOCKED;
                            owner_d[o] = win;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (packet_valid[owner_q[o]] && !buffer_full_in[o]) begin
                        grant_sel[o][owner_q[o]] = 1'b1;
                        if (packet_tail[owner_q[o]]) begin
                            state_d[o] = ST_GAP;
                            rr_d[o]    = wrap_inc(owner_q[o]);
                        end
                    end
                end
                default: state_d[o] = ST_IDLE;
            endcase
        end
    end

    always_comb begin : strobes
        grant_v = '0;
        pop_v   = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            grant_v[o] = |grant_sel[o];
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                pop_v[i] = pop_v[i] | grant_sel[o][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= ST_IDLE;
                owner_q[o] <= '0;
                rr_q[o]    <= '0;
            end
            route_err_q <= 1'b0;
        end else begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                rr_q[o]    <= rr_d[o];
            end
            route_err_q <= route_err_d;
        end
    end

    assign route_err = route_err_q;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_pop_chk
        logic [NUM_PORTS-1:0] src;
        always_comb begin
            src = '0;
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                src[o] = grant_sel[o][gi];
            end
        end
        a_pop_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(src));
    end

endmodule

// File: tb/tb_corner_switch_scheduler.sv
// Bench for corner_switch_scheduler: fixed vectors, directed wormhole traces and randomized
// traffic compared against a packet-level reference model.
module tb_corner_switch_scheduler;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       local_addr = 8'h55;
    logic [2:0]       packet_valid = '0;
    logic [2:0][7:0]  packet_addr = '0;
    logic [2:0]       packet_tail = '0;
    logic [2:0]       buffer_full_in = '0;
    logic [2:0][2:0]  grant_sel;
    logic [2:0]       grant_v;
    logic [2:0]       pop_v;
    logic             route_err;

    always #5 clk = ~clk;

    corner_switch_scheduler #(.NUM_PORTS(3), .HORIZ_PORT(0)) dut (
        .clk(clk), .rst(rst), .local_addr(local_addr),
        .packet_valid(packet_valid), .packet_addr(packet_addr), .packet_tail(packet_tail),
        .buffer_full_in(buffer_full_in), .grant_sel(grant_sel), .grant_v(grant_v),
        .pop_v(pop_v), .route_err(route_err)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] addr;
        logic       tail;
    } flit_t;
    flit_t fq[3][$];

    // Reference state: per output the packet owner (-1 = free), the dead cycle after a tail,
    // and the round-robin start; plus the sticky routing error.
    int m_owner[3];
    bit m_gap[3];
    int m_rr[3];
    bit m_err;

    typedef struct {
        logic [2:0] valid;
        logic [7:0] a0, a1, a2;
        logic [2:0] tail;
        logic [2:0] full;
        logic [8:0] gs;
        logic [2:0] pop;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] gv_of(input logic [8:0] g);
        return {|g[8:6], |g[5:3], |g[2:0]};
    endfunction

    function automatic logic [2:0] pop_of(input logic [8:0] g);
        return g[8:6] | g[5:3] | g[2:0];
    endfunction

    function automatic int dest_of(input int i, input logic [7:0] a);
        int d;
        if (a == local_addr) return 2;
        d = (a[7:4] != local_addr[7:4]) ? 0 : 1;
        if (i < 2 && d == i) return -1;
        return d;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < 3; o++) begin
            m_owner[o] = -1;
            m_gap[o]   = 1'b0;
            m_rr[o]    = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_step(output logic [8:0] e_gs);
        int dest[3];
        bit busy[3];
        int win[3];
        int c;
        logic [2:0][2:0] g;
        g = '0;
        for (int i = 0; i < 3; i++) begin
            dest[i] = packet_valid[i] ? dest_of(i, packet_addr[i]) : -1;
            if (packet_valid[i] && dest[i] < 0) m_err = 1'b1;
            busy[i] = (m_owner[0] == i) || (m_owner[1] == i) || (m_owner[2] == i);
        end
        for (int o = 0; o < 3; o++) begin
            win[o] = -1;
            if (!m_gap[o]) begin
                if (m_owner[o] >= 0) begin
                    if (packet_valid[m_owner[o]]) win[o] = m_owner[o];
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        c = (m_rr[o] + k) % 3;
                        if (win[o] < 0 && dest[c] == o && !busy[c]) win[o] = c;
                    end
                end
            end
            if (buffer_full_in[o]) win[o] = -1;
        end
        for (int o = 0; o < 3; o++) begin
            m_gap[o] = 1'b0;
            if (win[o] >= 0) begin
                g[o][win[o]] = 1'b1;
                if (packet_tail[win[o]]) begin
                    m_owner[o] = -1;
                    m_gap[o]   = 1'b1;
                    m_rr[o]    = (win[o] + 1) % 3;
                end else begin
                    m_owner[o] = win[o];
                end
            end
        end
        e_gs = g;
    endtask

    task automatic push_packet(input int i, input logic [7:0] addr, input int len);
        flit_t f;
        for (int n = 0; n < len; n++) begin
            f.addr = addr;
            f.tail = (n == len - 1);
            fq[i].push_back(f);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        packet_valid = '0;
        buffer_full_in = '0;
        for (int i = 0; i < 3; i++) fq[i].delete();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cycle(input logic [2:0] full, input logic [2:0] bubble, input string tag,
                         input bit use_exp, input logic [8:0] exp_gs);
        logic [8:0] e_gs;
        logic [2:0] e_pop;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (fq[i].size() > 0 && !bubble[i]) begin
                packet_valid[i] = 1'b1;
                packet_addr[i]  = fq[i][0].addr;
                packet_tail[i]  = fq[i][0].tail;
            end else begin
                packet_valid[i] = 1'b0;
                packet_addr[i]  = 8'($urandom);
                packet_tail[i]  = 1'($urandom);
            end
        end
        buffer_full_in = full;
        #2;
        chk({tag, " route_err"}, 32'(route_err), 32'(m_err));
        model_step(e_gs);
        e_pop = pop_of(e_gs);
        chk({tag, " grant_sel"}, 32'(grant_sel), 32'(e_gs));
        chk({tag, " grant_v"}, 32'(grant_v), 32'(gv_of(e_gs)));
        chk({tag, " pop_v"}, 32'(pop_v), 32'(e_pop));
        if (use_exp) chk({tag, " trace"}, 32'(grant_sel), 32'(exp_gs));
        for (int i = 0; i < 3; i++) if (e_pop[i]) void'(fq[i].pop_front());
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_addr(input int i);
        int cat;
        int x;
        int y;
        forever begin
            cat = $urandom_range(0, 2);
            if (!((i == 0 && cat == 1) || (i == 1 && cat == 2))) break;
        end
        if (cat == 0) return 8'h55;
        if (cat == 1) begin
            x = $urandom_range(0, 14);
            if (x >= 5) x++;
            return {4'(x), 4'($urandom)};
        end
        y = $urandom_range(0, 14);
        if (y >= 5) y++;
        return {4'h5, 4'(y)};
    endfunction

    initial begin
        logic [8:0] t2a[7];
        logic [8:0] t2b[4];
        logic [8:0] t3[11];
        logic [8:0] t4[7];

        vt[0] = '{3'b001, 8'h55, 8'h00, 8'h00, 3'b111, 3'b000, 9'b001_000_000, 3'b001};
        vt[1] = '{3'b111, 8'h57, 8'h35, 8'h55, 3'b111, 3'b000, 9'b100_001_010, 3'b111};
        vt[2] = '{3'b111, 8'h55, 8'h55, 8'h55, 3'b111, 3'b000, 9'b001_000_000, 3'b001};
        vt[3] = '{3'b111, 8'h55, 8'h55, 8'h55, 3'b111, 3'b100, 9'b000_000_000, 3'b000};
        vt[4] = '{3'b011, 8'h35, 8'h55, 8'h00, 3'b111, 3'b000, 9'b010_000_000, 3'b010};
        vt[5] = '{3'b110, 8'h00, 8'h57, 8'h57, 3'b111, 3'b000, 9'b000_100_000, 3'b100};
        vt[6] = '{3'b110, 8'h00, 8'h35, 8'h35, 3'b111, 3'b000, 9'b000_000_010, 3'b010};
        vt[7] = '{3'b000, 8'h55, 8'h55, 8'h55, 3'b111, 3'b000, 9'b000_000_000, 3'b000};
        vt[8] = '{3'b101, 8'h57, 8'h00, 8'h57, 3'b111, 3'b010, 9'b000_000_000, 3'b000};
        vt[9] = '{3'b011, 8'h57, 8'h57, 8'h00, 3'b000, 3'b000, 9'b000_001_000, 3'b001};

        t2a = '{9'b001_000_000, 9'b001_000_000, 9'b001_000_000, 9'b000_000_000,
                9'b010_000_000, 9'b010_000_000, 9'b010_000_000};
        t2b = '{9'b000_000_000, 9'b100_000_000, 9'b000_000_000, 9'b001_000_000};
        t3  = '{9'b000_000_100, 9'b000_000_100, 9'b0, 9'b0, 9'b0, 9'b0, 9'b0,
                9'b000_000_100, 9'b000_000_100, 9'b000_000_000, 9'b000_000_010};
        t4  = '{9'b010_000_000, 9'b000_000_000, 9'b000_000_000, 9'b010_000_000,
                9'b010_000_000, 9'b000_000_000, 9'b001_000_000};

        do_reset();
        #2;
        chk("reset grant_sel", 32'(grant_sel), 32'd0);
        chk("reset route_err", 32'(route_err), 32'd0);

        for (int v = 0; v < 10; v++) begin
            do_reset();
            packet_valid   = vt[v].valid;
            packet_addr    = {vt[v].a2, vt[v].a1, vt[v].a0};
            packet_tail    = vt[v].tail;
            buffer_full_in = vt[v].full;
            #2;
            chk($sformatf("vec%0d grant_sel", v), 32'(grant_sel), 32'(vt[v].gs));
            chk($sformatf("vec%0d grant_v", v), 32'(grant_v), 32'(gv_of(vt[v].gs)));
            chk($sformatf("vec%0d pop_v", v), 32'(pop_v), 32'(vt[v].pop));
        end

        // Contention on the local output, then a rotated winner.
        do_reset();
        push_packet(0, 8'h55, 3);
        push_packet(1, 8'h55, 3);
        for (int c = 0; c < 7; c++) cycle(3'b000, 3'b000, $sformatf("contend c%0d", c), 1'b1, t2a[c]);
        push_packet(0, 8'h55, 1);
        push_packet(2, 8'h55, 1);
        for (int c = 0; c < 4; c++) cycle(3'b000, 3'b000, $sformatf("rr c%0d", c), 1'b1, t2b[c]);

        // Downstream stall while locked, competing request ignored.
        do_reset();
        push_packet(2, 8'h35, 4);
        for (int c = 0; c < 11; c++) begin
            if (c == 2) push_packet(1, 8'h35, 1);
            cycle((c >= 2 && c <= 6) ? 3'b001 : 3'b000, 3'b000, $sformatf("stall c%0d", c), 1'b1, t3[c]);
        end

        // Valid bubbles inside a locked packet.
        do_reset();
        push_packet(1, 8'h55, 3);
        for (int c = 0; c < 7; c++) begin
            if (c == 1) push_packet(0, 8'h55, 1);
            cycle(3'b000, (c == 1 || c == 2) ? 3'b010 : 3'b000, $sformatf("bubble c%0d", c), 1'b1, t4[c]);
        end

        // U-turn on the horizontal link input: never popped, sticky error.
        do_reset();
        push_packet(0, 8'h35, 1);
        cycle(3'b000, 3'b000, "uturn c0", 1'b1, 9'b0);
        chk("uturn route_err set", 32'(route_err), 32'd1);
        fq[0].delete();
        cycle(3'b000, 3'b000, "uturn c1", 1'b1, 9'b0);
        chk("uturn route_err sticky", 32'(route_err), 32'd1);

        // Reset while an output is locked.
        do_reset();
        push_packet(0, 8'h57, 3);
        cycle(3'b000, 3'b000, "rstlock c0", 1'b1, 9'b000_001_000);
        do_reset();
        #2;
        chk("rstlock route_err", 32'(route_err), 32'd0);
        push_packet(2, 8'h57, 1);
        push_packet(1, 8'h35, 1);
        cycle(3'b000, 3'b000, "rstlock c1", 1'b1, 9'b000_100_010);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            logic [2:0] full;
            logic [2:0] bub;
            for (int i = 0; i < 3; i++) begin
                if (fq[i].size() < 4 && $urandom_range(0, 3) == 0)
                    push_packet(i, rand_addr(i), $urandom_range(1, 3));
                full[i] = ($urandom_range(0, 3) == 0);
                bub[i]  = ($urandom_range(0, 9) == 0);
            end
            cycle(full, bub, $sformatf("rand c%0d", c), 1'b0, 9'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
